// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: channel ids, response-tracker entry layout and the
// legal MEM_LAT range shared by the arbiter and its tracker.
package mem_port_arbiter_pkg;

    localparam logic CH_INST = 1'b0;
    localparam logic CH_DATA = 1'b1;

    localparam int TRK_VALID_W = 1;
    localparam int TRK_CHAN_W  = 1;
    localparam int TRK_KILL_W  = 1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    typedef struct packed {
        logic [TRK_VALID_W-1:0] valid;
        logic [TRK_CHAN_W-1:0]  chan;
        logic [TRK_KILL_W-1:0]  kill;
    } trk_entry_t;

    function automatic bit mem_lat_legal(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_resp_tracker.sv
// mem_resp_tracker: MEM_LAT-deep shift register of in-flight grants; the tail
// entry lines up with the SRAM read data of the grant it describes.
module mem_resp_tracker
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push_i,
    input  logic       push_chan_i,
    input  logic       flush_i,
    output trk_entry_t tail_o
);

    trk_entry_t [MEM_LAT-1:0] ent_q, ent_d;

    // A flush marks every live fetch entry, the one entering this cycle included.
    function automatic trk_entry_t age(input trk_entry_t e, input logic flush);
        trk_entry_t r;
        r = e;
        r.kill = e.kill | (flush & e.valid & (e.chan == CH_INST));
        return r;
    endfunction

    always_comb begin
        ent_d[0] = age(trk_entry_t'({push_i, push_chan_i, 1'b0}), flush_i);
        for (int k = 1; k < MEM_LAT; k++) ent_d[k] = age(ent_q[k-1], flush_i);
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) ent_q <= '0;
        else ent_q <= ent_d;

    assign tail_o = ent_q[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges fetch and data channels onto one synchronous SRAM port.
// Define ARB_ROUND_ROBIN_EN for alternating priority on contested cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_addr_ok,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_data_ok,
    input  logic                d_req,
    input  logic                d_wr,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_data_ok,
    input  logic                i_flush,
    output logic                m_en,
    output logic [DATA_W/8-1:0] m_wen,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata
);

    logic              gnt_i, gnt_d, grant;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    trk_entry_t        tail;

    if (!mem_lat_legal(MEM_LAT)) begin : g_lat_chk
        $error("mem_port_arbiter: MEM_LAT=%0d outside %0d..%0d", MEM_LAT, MEM_LAT_MIN, MEM_LAT_MAX);
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d, contested;

    assign contested = i_req & d_req;
    assign gnt_d     = d_req & ~(contested & (last_q == CH_DATA));
    assign gnt_i     = i_req & ~gnt_d;
    assign last_d    = contested ? (gnt_d ? CH_DATA : CH_INST) : last_q;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) last_q <= CH_INST;
        else last_q <= last_d;
`else
    assign gnt_d = d_req;
    assign gnt_i = i_req & ~d_req;
`endif

    assign grant = gnt_i | gnt_d;

    // Reset gates only the handshakes; internal state is already held in reset.
    assign i_addr_ok = resetn & gnt_i;
    assign d_addr_ok = resetn & gnt_d;
    assign m_en      = i_addr_ok | d_addr_ok;
    assign m_wen     = (d_addr_ok & d_wr) ? d_wstrb : '0;
    assign m_wdata   = d_wdata;
    assign m_addr_d  = grant ? (gnt_d ? d_addr : i_addr) : m_addr_q;
    assign m_addr    = m_addr_d;

    mem_resp_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_tracker (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (grant),
        .push_chan_i (gnt_d ? CH_DATA : CH_INST),
        .flush_i     (i_flush),
        .tail_o      (tail)
    );

    assign i_data_ok = tail.valid[0] & (tail.chan == CH_INST) & ~tail.kill[0] & ~i_flush;
    assign d_data_ok = tail.valid[0] & (tail.chan == CH_DATA);
    assign i_rdata_d = i_data_ok ? m_rdata : i_rdata_q;
    assign d_rdata_d = d_data_ok ? m_rdata : d_rdata_q;
    assign i_rdata   = i_rdata_d;
    assign d_rdata   = d_rdata_d;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            m_addr_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            m_addr_q  <= m_addr_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, directed corner sequences and random
// traffic checked against a queue-based model of the arbiter and SRAM.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LAT = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk, resetn;
    logic        i_req, i_addr_ok, i_data_ok, d_req, d_wr, d_addr_ok, d_data_ok, i_flush, m_en;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [3:0]  d_wstrb, m_wen;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_rdata(i_rdata), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_rdata(d_rdata), .d_data_ok(d_data_ok), .i_flush(i_flush),
        .m_en(m_en), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h2408_0001 : (i == 4) ? 32'h1122_3344 : 32'hA500_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // SRAM responder: samples the port mid-cycle, returns data LAT cycles later.
    logic [31:0] sram [64];
    logic [31:0] pipe [LAT];
    assign m_rdata = pipe[LAT-1];
    initial begin
        logic cen;
        logic [3:0] cwen;
        logic [5:0] cidx;
        logic [31:0] cwd;
        for (int i = 0; i < 64; i++) sram[i] = init_word(i);
        for (int k = 0; k < LAT; k++) pipe[k] = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            cen = m_en; cwen = m_wen; cidx = m_addr[7:2]; cwd = m_wdata;
            @(posedge clk);
            #1;
            for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = cen ? sram[cidx] : 32'hDEAD_BEEF;
            if (cen) for (int b = 0; b < 4; b++) if (cwen[b]) sram[cidx][8*b+:8] = cwd[8*b+:8];
        end
    end

    int vec, miss;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending responses keyed by the cycle they are due.
    typedef struct { int due; bit chan; bit wr; bit kill; logic [31:0] data; } pend_t;
    pend_t       q[$];
    logic [31:0] mmem [64];
    logic [31:0] m_last_addr, m_li;
    bit          m_last, m_gi, m_gd;
    int          cyc;

    task automatic model_step();
        bit gi, gd, has, ei, ed;
        logic [31:0] ea;
        logic [5:0] idx;
        pend_t p;
        if (!resetn) begin
            q.delete(); m_last_addr = '0; m_li = '0; m_last = CH_INST;
        end
        gi = 0; gd = 0;
        if (resetn) begin
            if (i_req && d_req) begin
                gd = !RR || (m_last == CH_INST);
                gi = !gd;
            end else begin
                gi = i_req; gd = d_req;
            end
        end
        ea = gd ? d_addr : gi ? i_addr : m_last_addr;
        chk("i_addr_ok", 32'(i_addr_ok), 32'(gi));
        chk("d_addr_ok", 32'(d_addr_ok), 32'(gd));
        chk("m_en", 32'(m_en), 32'(gi | gd));
        chk("m_wen", 32'(m_wen), (gd && d_wr) ? 32'(d_wstrb) : 32'h0);
        if (resetn) chk("m_addr", m_addr, ea);
        if (gd && d_wr) chk("m_wdata", m_wdata, d_wdata);
        has = resetn && q.size() > 0 && q[0].due == cyc;
        ei  = has && q[0].chan == CH_INST && !q[0].kill && !i_flush;
        ed  = has && q[0].chan == CH_DATA;
        chk("i_data_ok", 32'(i_data_ok), 32'(ei));
        chk("d_data_ok", 32'(d_data_ok), 32'(ed));
        chk("i_rdata", i_rdata, ei ? q[0].data : m_li);
        if (ed && !q[0].wr) chk("d_rdata", d_rdata, q[0].data);
        if (ei) m_li = q[0].data;
        if (has) void'(q.pop_front());
        if (i_flush) foreach (q[k]) if (q[k].chan == CH_INST) q[k].kill = 1'b1;
        if (gi || gd) begin
            idx = ea[7:2];
            p.due = cyc + LAT; p.chan = gd; p.wr = gd && d_wr; p.kill = gi && i_flush; p.data = mmem[idx];
            q.push_back(p);
            if (p.wr) for (int b = 0; b < 4; b++) if (d_wstrb[b]) mmem[idx][8*b+:8] = d_wdata[8*b+:8];
            m_last_addr = ea;
            if (i_req && d_req) m_last = gd;
        end
        m_gi = gi; m_gd = gd;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [3:0] ws, input logic [31:0] da, input logic [31:0] wd, input bit fl);
        i_req = ir; i_addr = ia; d_req = dr; d_wr = dw; d_wstrb = ws; d_addr = da; d_wdata = wd; i_flush = fl;
    endtask

    task automatic idle(input int n);
        drv(0, '0, 0, 0, '0, '0, '0, 0);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
    endtask

    typedef struct {
        bit ir; bit dr; bit dw; logic [3:0] ws; logic [31:0] ia; logic [31:0] da;
        bit ei; bit ed; logic [3:0] ewen; logic [31:0] eaddr;
    } row_t;
    row_t tbl [11];

    initial begin
        bit pi, pd, pdw;
        logic [31:0] pia, pda, pwd;
        logic [3:0] pws;
        int cnt;
        vec = 0; miss = 0; cyc = 0;
        m_last_addr = '0; m_li = '0; m_last = CH_INST;
        for (int i = 0; i < 64; i++) mmem[i] = init_word(i);
        tbl[0]  = '{0, 0, 0, 4'h0, 32'h0,   32'h0,   0, 0, 4'h0, 32'h0};
        tbl[1]  = '{1, 0, 0, 4'h0, 32'h100, 32'h0,   1, 0, 4'h0, 32'h100};
        tbl[2]  = '{0, 0, 0, 4'h0, 32'h0,   32'h0,   0, 0, 4'h0, 32'h100};
        tbl[3]  = '{0, 1, 0, 4'hF, 32'h0,   32'h204, 0, 1, 4'h0, 32'h204};
        tbl[4]  = '{0, 1, 1, 4'h5, 32'h0,   32'h208, 0, 1, 4'h5, 32'h208};
        tbl[5]  = '{0, 0, 0, 4'h0, 32'h0,   32'h0,   0, 0, 4'h0, 32'h208};
        for (int k = 6; k < 10; k++) begin
            bit dwin;
            dwin = !RR || (k % 2 == 0);
            tbl[k] = '{1, 1, 0, 4'h0, 32'h10C, 32'h218, !dwin, dwin, 4'h0, dwin ? 32'h218 : 32'h10C};
        end
        tbl[10] = '{0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, RR ? 32'h10C : 32'h218};

        resetn = 1'b0;
        drv(0, '0, 0, 0, '0, '0, '0, 0);
        @(posedge clk);
        #1;
        idle(2);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            drv(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].ws, tbl[i].da, 32'hC0DE_0000 + 32'(i), 0);
            #1;
            chk($sformatf("tbl%0d_i_ok", i), 32'(i_addr_ok), 32'(tbl[i].ei));
            chk($sformatf("tbl%0d_d_ok", i), 32'(d_addr_ok), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_m_wen", i), 32'(m_wen), 32'(tbl[i].ewen));
            chk($sformatf("tbl%0d_m_addr", i), m_addr, tbl[i].eaddr);
            tick();
        end
        idle(LAT + 1);

        // Single fetch: accepted at once, data LAT cycles later.
        drv(1, 32'hBFC0_0000, 0, 0, '0, '0, '0, 0);
        #1;
        chk("s1_i_addr_ok", 32'(i_addr_ok), 32'h1);
        chk("s1_m_addr", m_addr, 32'hBFC0_0000);
        tick();
        drv(0, '0, 0, 0, '0, '0, '0, 0);
        for (int k = 1; k < LAT; k++) begin
            #1;
            chk("s1_early_ok", 32'(i_data_ok), 32'h0);
            tick();
        end
        #1;
        chk("s1_i_data_ok", 32'(i_data_ok), 32'h1);
        chk("s1_i_rdata", i_rdata, 32'h2408_0001);
        idle(2);

        // Contested cycle: data first, responses in grant order.
        do_reset();
        drv(1, 32'h0000_0040, 1, 0, '0, 32'h0000_0050, '0, 0);
        #1;
        chk("s2_d_first", 32'(d_addr_ok), 32'h1);
        chk("s2_i_denied", 32'(i_addr_ok), 32'h0);
        tick();
        drv(1, 32'h0000_0040, 0, 0, '0, '0, '0, 0);
        #1;
        chk("s2_i_next", 32'(i_addr_ok), 32'h1);
        tick();
        idle(LAT - 2);
        #1;
        chk("s2_d_resp", 32'(d_data_ok), 32'h1);
        chk("s2_no_i_yet", 32'(i_data_ok), 32'h0);
        tick();
        #1;
        chk("s2_i_resp", 32'(i_data_ok), 32'h1);
        idle(LAT + 1);

        // Three fetches with a flush alongside the third, then one more.
        drv(1, 32'h300, 0, 0, '0, '0, '0, 0); tick();
        drv(1, 32'h304, 0, 0, '0, '0, '0, 0); tick();
        drv(1, 32'h308, 0, 0, '0, '0, '0, 1); tick();
        drv(1, 32'h30C, 0, 0, '0, '0, '0, 0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            cnt += int'(i_data_ok);
            tick();
            drv(0, '0, 0, 0, '0, '0, '0, 0);
        end
        chk("s4_killed", 32'(cnt), 32'h0);
        #1;
        chk("s4_after_flush", 32'(i_data_ok), 32'h1);
        chk("s4_rdata", i_rdata, init_word(3));
        idle(LAT + 1);

        // Partial write then read-back of the merged word.
        drv(0, '0, 1, 1, 4'b0011, 32'h8000_0010, 32'hAABB_CCDD, 0);
        #1;
        chk("s5_m_wen", 32'(m_wen), 32'h3);
        tick();
        drv(0, '0, 0, 0, '0, '0, '0, 0);
        repeat (LAT - 1) tick();
        #1;
        chk("s5_wr_ack", 32'(d_data_ok), 32'h1);
        tick();
        drv(0, '0, 1, 0, 4'hF, 32'h8000_0010, '0, 0);
        tick();
        drv(0, '0, 0, 0, '0, '0, '0, 0);
        repeat (LAT - 1) tick();
        #1;
        chk("s5_rd_ack", 32'(d_data_ok), 32'h1);
        chk("s5_merged", d_rdata, 32'h1122_CCDD);
        idle(LAT + 1);

        // Reset with two fetches in flight.
        drv(1, 32'h400, 0, 0, '0, '0, '0, 0); tick();
        drv(1, 32'h404, 0, 0, '0, '0, '0, 0); tick();
        resetn = 1'b0;
        #1;
        chk("s6_i_addr_ok", 32'(i_addr_ok), 32'h0);
        chk("s6_m_en", 32'(m_en), 32'h0);
        chk("s6_m_wen", 32'(m_wen), 32'h0);
        chk("s6_data_ok", 32'(i_data_ok | d_data_ok), 32'h0);
        chk("s6_i_rdata", i_rdata, 32'h0);
        tick();
        resetn = 1'b1;
        drv(0, '0, 0, 0, '0, '0, '0, 0);
        cnt = 0;
        repeat (LAT + 2) begin
            #1;
            cnt += int'(i_data_ok | d_data_ok);
            tick();
        end
        chk("s6_no_resp", 32'(cnt), 32'h0);

        // Random traffic; requesters hold until granted.
        pi = 0; pd = 0; pdw = 0; pia = '0; pda = '0; pwd = '0; pws = '0;
        repeat (600) begin
            if (!pi && $urandom_range(0, 2) == 0) begin
                pi = 1; pia = $urandom; pia[1:0] = 2'b00;
            end
            if (!pd && $urandom_range(0, 2) == 0) begin
                pd = 1; pdw = 1'($urandom); pws = 4'($urandom); pwd = $urandom; pda = $urandom; pda[1:0] = 2'b00;
            end
            drv(pi, pia, pd, pdw, pws, pda, pwd, $urandom_range(0, 11) == 0);
            tick();
            if (m_gi) pi = 0;
            if (m_gd) pd = 0;
        end
        idle(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
